seg_pattern_decoder: RTL and testbench



---
 rtl/seg_pattern_decoder.sv | 163 ++++++++++++++++
 tb/tb_seg_pattern_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pattern_decoder.sv
// seg_pattern_decoder
//   Samples an active-low 7-segment bus ({g,f,e,d,c,b,a}), waits for the
//   pattern to hold for STABLE_CYCLES enabled samples, then decodes it back
//   to a hex digit. Digits leave on a valid/ready handshake. Unrecognised
//   stable patterns pulse out_error and bump a saturating error counter.
//
//   Optional feature macro: SEG_BLANK_EN. When defined, a stable all-off
//   pattern (7'b1111111) is a legal blank digit and is dropped silently.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   seg_in     in   [6:0] active-low segment pattern
//   seg_en     in   sample strobe; seg_in ignored when low
//   out_value  out  [3:0] decoded hex value
//   out_valid  out  out_value valid, held until accepted
//   out_ready  in   consumer accept
//   out_error  out  one-cycle pulse for an unrecognised stable pattern
//   err_count  out  [ERR_W-1:0] saturating count of out_error pulses
//   err_clr    in   synchronous clear of err_count
module seg_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  input  logic             seg_en,
  output logic [3:0]       out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_error,
  output logic [ERR_W-1:0] err_count,
  input  logic             err_clr
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_HOLD, S_SETTLE, S_OUT} state_e;

  // {valid, value}; exact match only
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  state_e           state_q;
  logic [6:0]       cap_q, cap_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             changed_q;
  logic [3:0]       out_value_q;
  logic             out_valid_q;
  logic             out_error_q;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic       diff, stable, blank_ok, err_fire;
  logic [4:0] dec;

  assign diff   = seg_en && (seg_in != cap_q);
  assign stable = (cnt_q == STABLE);
  assign dec    = seg_decode(cap_q);

`ifdef SEG_BLANK_EN
  assign blank_ok = (cap_q == 7'b1111111);
`else
  assign blank_ok = 1'b0;
`endif

  // A differing sample on the decode edge restarts capture and suppresses
  // the decode, so the error only fires when the stable pattern survives.
  assign err_fire = (state_q == S_SETTLE) && stable && !diff && !dec[4] && !blank_ok;

  always_comb begin
    cap_d = cap_q;
    cnt_d = cnt_q;
    if (seg_en) begin
      if (seg_in != cap_q) begin
        cap_d = seg_in;
        cnt_d = CW'(1);
      end else if (!stable) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (err_clr)
      err_count_d = err_fire ? ERR_W'(1) : '0;
    else if (err_fire && !(&err_count_q))
      err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      cap_q       <= 7'b1111111;
      cnt_q       <= '0;
      changed_q   <= 1'b0;
      out_value_q <= 4'h0;
      out_valid_q <= 1'b0;
      out_error_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
      out_error_q <= err_fire;
      case (state_q)
        S_HOLD: begin
          if (diff) state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (stable && !diff) begin
            if (dec[4]) begin
              out_value_q <= dec[3:0];
              out_valid_q <= 1'b1;
              state_q     <= S_OUT;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_OUT: begin
          // output is frozen here; a new pattern is only remembered
          if (diff) changed_q <= 1'b1;
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            changed_q   <= 1'b0;
            state_q     <= (changed_q || diff) ? S_SETTLE : S_HOLD;
          end
        end
        default: state_q <= S_HOLD;
      endcase
    end
  end

  assign out_value = out_value_q;
  assign out_valid = out_valid_q;
  assign out_error = out_error_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
module tb_seg_pattern_decoder;

  localparam int SC = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic          seg_en;
  logic [3:0]    out_value;
  logic          out_valid;
  logic          out_ready;
  logic          out_error;
  logic [EW-1:0] err_count;
  logic          err_clr;

  int nvec = 0;
  int nmis = 0;

  // entry: {is_error, value}
  logic [4:0] exp_q[$];

  seg_pattern_decoder #(.STABLE_CYCLES(SC), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_en(seg_en),
    .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_error(out_error), .err_count(err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // scoreboard: pops at each handshake or error pulse
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nmis++;
          $display("FAIL sb_unexpected_value got %h, queue empty", out_value);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          if ({1'b0, out_value} !== e) begin
            nmis++;
            $display("FAIL sb_value got %b_%h exp %b_%h", 1'b0, out_value, e[4], e[3:0]);
          end
        end
      end
      if (out_error) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nmis++;
          $display("FAIL sb_unexpected_error queue empty");
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          if (e[4] !== 1'b1) begin
            nmis++;
            $display("FAIL sb_error got error exp value %h", e[3:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; seg_en = 1'b0; seg_in = 7'b1111111; out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    nvec++;
    if ({out_valid, out_value, out_error, err_count} !== {1'b0, 4'h0, 1'b0, {EW{1'b0}}}) begin
      nmis++;
      $display("FAIL reset_values got v=%b val=%h e=%b cnt=%0d", out_valid, out_value, out_error, err_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_digit();
    seg_en = 1'b1; seg_in = 7'b0100100;
    exp_q.push_back({1'b0, 4'h2});
    for (int k = 1; k <= SC + 1; k++) begin
      tick();
      nvec++;
      if (out_valid !== (k >= SC + 1)) begin
        nmis++;
        $display("FAIL latency_edge%0d got valid=%b exp %b", k, out_valid, (k >= SC + 1));
      end
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      nvec++;
      if ({out_valid, out_value} !== {1'b1, 4'h2}) begin
        nmis++;
        $display("FAIL hold_valid got v=%b val=%h exp v=1 val=2", out_valid, out_value);
      end
    end
    accept();
    nvec++;
    if (out_valid !== 1'b0) begin
      nmis++;
      $display("FAIL accept_clear got valid=%b exp 0", out_valid);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      nvec++;
      if ({out_valid, out_error} !== 2'b00) begin
        nmis++;
        $display("FAIL no_reemit got v=%b e=%b exp 0 0", out_valid, out_error);
      end
    end
  endtask

  task automatic test_glitch_and_enable();
    seg_in = 7'b0110000;
    for (int k = 0; k < 3; k++) tick();
    seg_in = 7'b0011001;
    exp_q.push_back({1'b0, 4'h4});
    for (int k = 1; k <= SC + 1; k++) begin
      tick();
      nvec++;
      if (out_valid !== (k >= SC + 1)) begin
        nmis++;
        $display("FAIL glitch_edge%0d got valid=%b exp %b", k, out_valid, (k >= SC + 1));
      end
    end
    nvec++;
    if (out_value !== 4'h4) begin
      nmis++;
      $display("FAIL glitch_value got %h exp 4", out_value);
    end
    accept();
    // enable toggling: enabled samples on odd steps only
    seg_in = 7'b0110000;
    exp_q.push_back({1'b0, 4'h3});
    for (int k = 1; k <= 2 * SC; k++) begin
      seg_en = (k % 2 == 1);
      tick();
      nvec++;
      if (out_valid !== (k >= 2 * SC)) begin
        nmis++;
        $display("FAIL enable_step%0d got valid=%b exp %b", k, out_valid, (k >= 2 * SC));
      end
    end
    seg_en = 1'b1;
    nvec++;
    if (out_value !== 4'h3) begin
      nmis++;
      $display("FAIL enable_value got %h exp 3", out_value);
    end
    accept();
  endtask

  task automatic test_invalid();
    seg_in = 7'b0101010;
    exp_q.push_back({1'b1, 4'h0});
    for (int k = 1; k <= 10; k++) begin
      tick();
      nvec++;
      if ({out_error, out_valid} !== {(k == SC + 1), 1'b0}) begin
        nmis++;
        $display("FAIL invalid_edge%0d got e=%b v=%b exp e=%b v=0", k, out_error, out_valid, (k == SC + 1));
      end
    end
    nvec++;
    if (err_count !== EW'(1)) begin
      nmis++;
      $display("FAIL invalid_count got %0d exp 1", err_count);
    end
  endtask

  task automatic test_back_to_back();
    seg_in = 7'b0000010;
    exp_q.push_back({1'b0, 4'h6});
    for (int k = 0; k < SC + 1; k++) tick();
    nvec++;
    if ({out_valid, out_value} !== {1'b1, 4'h6}) begin
      nmis++;
      $display("FAIL b2b_first got v=%b val=%h exp v=1 val=6", out_valid, out_value);
    end
    seg_in = 7'b1111000;
    exp_q.push_back({1'b0, 4'h7});
    for (int k = 0; k < 8; k++) begin
      tick();
      nvec++;
      if ({out_valid, out_value} !== {1'b1, 4'h6}) begin
        nmis++;
        $display("FAIL b2b_frozen got v=%b val=%h exp v=1 val=6", out_valid, out_value);
      end
    end
    accept();
    nvec++;
    if (out_valid !== 1'b0) begin
      nmis++;
      $display("FAIL b2b_drop got valid=%b exp 0", out_valid);
    end
    tick();
    nvec++;
    if ({out_valid, out_value} !== {1'b1, 4'h7}) begin
      nmis++;
      $display("FAIL b2b_second got v=%b val=%h exp v=1 val=7", out_valid, out_value);
    end
    accept();
  endtask

  task automatic test_err_sat();
    logic [6:0] pats [5];
    logic [EW-1:0] expc [4];
    pats = '{7'b0101010, 7'b0101011, 7'b0101100, 7'b0101101, 7'b0101110};
    expc = '{EW'(1), EW'(2), EW'(3), EW'(3)};
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    nvec++;
    if (err_count !== '0) begin
      nmis++;
      $display("FAIL errclr got %0d exp 0", err_count);
    end
    for (int i = 0; i < 4; i++) begin
      seg_in = pats[i];
      exp_q.push_back({1'b1, 4'h0});
      for (int k = 0; k < SC + 1; k++) tick();
      nvec++;
      if ({out_error, err_count} !== {1'b1, expc[i]}) begin
        nmis++;
        $display("FAIL errsat_%0d got e=%b cnt=%0d exp e=1 cnt=%0d", i, out_error, err_count, expc[i]);
      end
    end
    seg_in = pats[4];
    exp_q.push_back({1'b1, 4'h0});
    for (int k = 0; k < SC; k++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    nvec++;
    if ({out_error, err_count} !== {1'b1, EW'(1)}) begin
      nmis++;
      $display("FAIL errclr_coincident got e=%b cnt=%0d exp e=1 cnt=1", out_error, err_count);
    end
  endtask

  task automatic test_blank_and_reset();
    logic [EW-1:0] c0;
    logic          eseen;
    seg_in = 7'b1000000;
    exp_q.push_back({1'b0, 4'h0});
    for (int k = 0; k < SC + 1; k++) tick();
    nvec++;
    if ({out_valid, out_value} !== {1'b1, 4'h0}) begin
      nmis++;
      $display("FAIL digit0 got v=%b val=%h exp v=1 val=0", out_valid, out_value);
    end
    accept();
    c0 = err_count;
    eseen = 1'b0;
    seg_in = 7'b1111111;
`ifndef SEG_BLANK_EN
    exp_q.push_back({1'b1, 4'h0});
`endif
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_error) eseen = 1'b1;
    end
    nvec++;
`ifdef SEG_BLANK_EN
    if ({eseen, err_count, out_valid} !== {1'b0, c0, 1'b0}) begin
      nmis++;
      $display("FAIL blank got e=%b cnt=%0d v=%b exp e=0 cnt=%0d v=0", eseen, err_count, out_valid, c0);
    end
`else
    if ({eseen, err_count, out_valid} !== {1'b1, c0 + 1'b1, 1'b0}) begin
      nmis++;
      $display("FAIL blank got e=%b cnt=%0d v=%b exp e=1 cnt=%0d v=0", eseen, err_count, out_valid, c0 + 1'b1);
    end
`endif
    // pending digit 1 is dropped by reset; nothing pushed for it
    seg_in = 7'b1111001;
    for (int k = 0; k < SC + 1; k++) tick();
    nvec++;
    if (out_valid !== 1'b1) begin
      nmis++;
      $display("FAIL pre_reset got valid=%b exp 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, out_value, err_count} !== {1'b0, 4'h0, {EW{1'b0}}}) begin
      nmis++;
      $display("FAIL async_reset got v=%b val=%h cnt=%0d exp 0 0 0", out_valid, out_value, err_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_digit();
    test_glitch_and_enable();
    test_invalid();
    test_back_to_back();
    test_err_sat();
    test_blank_and_reset();
    nvec++;
    if (exp_q.size() != 0) begin
      nmis++;
      $display("FAIL sb_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
